// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the shared UART arbiter.
// slave: arbiter side; master: requesters plus the uart transmitter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           tx_data;
    logic                 tx_send;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;
    logic                 active;
    logic                 err_timeout;

    modport slave (
        input  req,
        input  req_data,
        input  tx_busy,
        output ack,
        output tx_data,
        output tx_send,
        output grant_id,
        output active,
        output err_timeout
    );

    modport master (
        output req,
        output req_data,
        output tx_busy,
        input  ack,
        input  tx_data,
        input  tx_send,
        input  grant_id,
        input  active,
        input  err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional busy-rise watchdog enabled by defining UART_ARB_BUSY_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_WAIT  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    if (NUM_REQ < 2 || NUM_REQ > 16 || NUM_REQ > (1 << ID_W) || BUSY_WAIT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [7:0]         tx_data_q;
    logic               tx_send_q;
    logic               active_q;
    logic [GAP_W-1:0]   gap_cnt_q;

    logic               win_vld_d;
    logic [ID_W-1:0]    win_idx_d;
    logic [7:0]         win_data_d;

`ifdef UART_ARB_BUSY_TIMEOUT_EN
    localparam int BW_W = $clog2(BUSY_WAIT + 1);
    logic [BW_W-1:0]    busy_cnt_q;
    logic               err_timeout_q;
`endif

    // Winner search: smallest rotated distance from ptr_q+1 among set req bits
    always_comb begin
        int   dist_v;
        int   best_v;
        logic take_v;
        dist_v     = 0;
        best_v     = NUM_REQ;
        take_v     = 1'b0;
        win_vld_d  = 1'b0;
        win_idx_d  = '0;
        win_data_d = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist_v     = j + NUM_REQ - 1 - int'(ptr_q);
            dist_v     = (dist_v >= NUM_REQ) ? (dist_v - NUM_REQ) : dist_v;
            take_v     = bus.req[j] && (dist_v < best_v);
            best_v     = take_v ? dist_v : best_v;
            win_vld_d  = take_v ? 1'b1 : win_vld_d;
            win_idx_d  = take_v ? ID_W'(j) : win_idx_d;
            win_data_d = take_v ? bus.req_data[8*j +: 8] : win_data_d;
        end
    end

    // Arbitration and byte sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            grant_id_q <= '0;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_send_q  <= 1'b0;
            active_q   <= 1'b0;
            gap_cnt_q  <= '0;
`ifdef UART_ARB_BUSY_TIMEOUT_EN
            busy_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            ack_q     <= '0;
            tx_send_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Busy while idle means someone else is driving the transmitter
                    if (win_vld_d && !bus.tx_busy) begin
                        tx_data_q  <= win_data_d;
                        grant_id_q <= win_idx_d;
                        ptr_q      <= win_idx_d;
                        ack_q      <= NUM_REQ'(1) << win_idx_d;
                        active_q   <= 1'b1;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    tx_send_q <= 1'b1;
                    state_q   <= ST_WAIT_BUSY;
`ifdef UART_ARB_BUSY_TIMEOUT_EN
                    busy_cnt_q <= '0;
`endif
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= ST_WAIT_DONE;
`ifdef UART_ARB_BUSY_TIMEOUT_EN
                    end else if (busy_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
                        err_timeout_q <= 1'b1;
                        active_q      <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + BW_W'(1);
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_q <= GAP_W'(GAP_CYCLES - 1);
                            state_q   <= ST_GAP;
                        end else begin
                            active_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        active_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_send  = tx_send_q;
    assign bus.grant_id = grant_id_q;
    assign bus.active   = active_q;
`ifdef UART_ARB_BUSY_TIMEOUT_EN
    assign bus.err_timeout = err_timeout_q;
`else
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single grant, busy handshake and gap,
// mid-transfer reset, round-robin rotation, busy-in-idle, optional busy timeout.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 2;
    localparam int GAP = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR), .ID_W(IW), .GAP_CYCLES(GAP), .BUSY_WAIT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ack"},      32'(bus.ack),         32'h0);
        check({tag, "_tx_send"},  32'(bus.tx_send),     32'h0);
        check({tag, "_tx_data"},  32'(bus.tx_data),     32'h0);
        check({tag, "_grant_id"}, 32'(bus.grant_id),    32'h0);
        check({tag, "_active"},   32'(bus.active),      32'h0);
        check({tag, "_err"},      32'(bus.err_timeout), 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.active !== 1'b0 && k < 60) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, 32'(bus.active), 32'h0);
    endtask

    // One byte from grant to return to IDLE; busy is raised right after tx_send
    task automatic serve(input int idx, input logic [7:0] data, input string tag);
        int k;
        k = 0;
        while (bus.ack === '0 && k < 40) begin
            tick();
            k++;
        end
        check({tag, "_ack"},   32'(bus.ack),      32'd1 << idx);
        check({tag, "_grant"}, 32'(bus.grant_id), 32'(idx));
        tick();
        check({tag, "_ack_once"}, 32'(bus.ack),     32'h0);
        check({tag, "_send"},     32'(bus.tx_send), 32'h1);
        check({tag, "_data"},     32'(bus.tx_data), 32'(data));
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Single request on lane 2
        bus.req_data = {8'h13, 8'hA5, 8'h11, 8'h10};
        bus.req      = 4'b0100;
        tick();
        check("single_ack",     32'(bus.ack),      32'h4);
        check("single_grant",   32'(bus.grant_id), 32'h2);
        check("single_data",    32'(bus.tx_data),  32'hA5);
        check("single_nosend",  32'(bus.tx_send),  32'h0);
        bus.req                = 4'b0000;
        bus.req_data[23:16]    = 8'h5A;
        tick();
        check("single_send",    32'(bus.tx_send),  32'h1);
        check("single_ack_off", 32'(bus.ack),      32'h0);
        check("single_data2",   32'(bus.tx_data),  32'hA5);
        tick();
        check("send_one_cycle", 32'(bus.tx_send),  32'h0);
        tick();
        tick();
        bus.tx_busy = 1'b1;

        // Long busy with a pending request on lane 0
        bus.req            = 4'b0001;
        bus.req_data[7:0]  = 8'h3C;
        repeat (1000) tick();
        check("busy_active",  32'(bus.active),  32'h1);
        check("busy_no_ack",  32'(bus.ack),     32'h0);
        check("busy_data",    32'(bus.tx_data), 32'hA5);
        bus.tx_busy = 1'b0;
        tick();
        // Edges after the one that samples busy low: GAP cycles, IDLE, SEND
        n = 0;
        while (bus.tx_send !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("gap_latency", 32'(n),            32'(GAP + 2));
        check("gap_data",    32'(bus.tx_data),  32'h3C);
        check("gap_grant",   32'(bus.grant_id), 32'h0);
        bus.req     = 4'b0000;
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        wait_idle("after_gap");

        // Reset during WAIT_DONE
        bus.req            = 4'b0010;
        bus.req_data[15:8] = 8'h77;
        tick();
        check("mid_ack", 32'(bus.ack), 32'h2);
        bus.req = 4'b0000;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("midrst");
        rst_n       = 1'b1;
        bus.tx_busy = 1'b0;
        tick();
        check("midrst_no_ack", 32'(bus.ack),    32'h0);
        check("midrst_idle",   32'(bus.active), 32'h0);

        // All requesters held: strict rotation from requester 0
        bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req      = 4'b1111;
        serve(0, 8'h10, "rr0");
        serve(1, 8'h11, "rr1");
        serve(2, 8'h12, "rr2");
        serve(3, 8'h13, "rr3");
        serve(0, 8'h10, "rr4");
        bus.req = 4'b0000;

        // Busy while idle blocks arbitration
        bus.tx_busy       = 1'b1;
        bus.req           = 4'b0001;
        bus.req_data[7:0] = 8'h42;
        repeat (5) tick();
        check("idlebusy_no_ack",  32'(bus.ack),     32'h0);
        check("idlebusy_no_send", 32'(bus.tx_send), 32'h0);
        check("idlebusy_idle",    32'(bus.active),  32'h0);
        bus.tx_busy = 1'b0;
        tick();
        check("idlebusy_ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("idlebusy_send", 32'(bus.tx_send), 32'h1);
        check("idlebusy_data", 32'(bus.tx_data), 32'h42);
        bus.tx_busy = 1'b1;
        tick();
        bus.tx_busy = 1'b0;
        wait_idle("idlebusy");

`ifdef UART_ARB_BUSY_TIMEOUT_EN
        // Busy never rises: timeout 8 clocks after entering WAIT_BUSY
        bus.req             = 4'b0100;
        bus.req_data[23:16] = 8'hE1;
        tick();
        check("to_ack", 32'(bus.ack), 32'h4);
        bus.req = 4'b0000;
        tick();
        check("to_send", 32'(bus.tx_send), 32'h1);
        repeat (7) tick();
        check("to_err_early",  32'(bus.err_timeout), 32'h0);
        check("to_active",     32'(bus.active),      32'h1);
        tick();
        check("to_err_set",    32'(bus.err_timeout), 32'h1);
        check("to_idle",       32'(bus.active),      32'h0);
        bus.req             = 4'b1000;
        bus.req_data[31:24] = 8'hB7;
        serve(3, 8'hB7, "to_next");
        bus.req = 4'b0000;
        check("to_err_sticky", 32'(bus.err_timeout), 32'h1);
`else
        check("err_tied", 32'(bus.err_timeout), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
